// File: rtl/queue_ctrl_pkg.sv
// Shared defaults, width helpers and payload type for the queue controller.
// Optional combinational bypass is selected with QUEUE_CTRL_FLOW_EN in the top.
package queue_ctrl_pkg;

  localparam int DATA_W_DEF = 115;
  localparam int DEPTH_DEF  = 2;

  typedef logic [DATA_W_DEF-1:0] payload_t;

  // Pointer width; a single-entry queue would still need one address bit.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/queue_wrap_ptr.sv
// Wrapping ADDR_W-bit pointer with increment and synchronous clear.
// DEPTH is a power of two, so natural binary overflow provides the wrap.
module queue_wrap_ptr #(
  parameter int ADDR_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] value
);

  // Clear has priority so a flush discards any same-cycle increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/queue_ctrl_2x115.sv
// Pointer/handshake controller for a 2-entry 115-bit queue on an external 1R1W memory.
// Define QUEUE_CTRL_FLOW_EN to enable the empty-queue combinational bypass.
module queue_ctrl_2x115
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [DATA_W-1:0] mem_R0_data
);

  logic [ADDR_W-1:0] enq_ptr;
  logic [ADDR_W-1:0] deq_ptr;
  logic [ADDR_W-1:0] ptr_diff;
  logic              maybe_full;
  logic              ptr_match;
  logic              empty;
  logic              full;
  logic              do_enq;
  logic              do_deq;
  logic              pass;
  logic              enq_fire;
  logic              deq_fire;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;
  assign enq_ready = ~full;

`ifdef QUEUE_CTRL_FLOW_EN
  // An empty queue forwards the producer straight to the consumer.
  assign deq_valid = ~empty | enq_valid;
  assign deq_bits  = empty ? enq_bits : mem_R0_data;
  assign pass      = empty & enq_valid & deq_ready;
`else
  assign deq_valid = ~empty;
  assign deq_bits  = mem_R0_data;
  assign pass      = 1'b0;
`endif

  assign do_enq   = enq_valid & enq_ready;
  assign do_deq   = deq_valid & deq_ready;
  assign enq_fire = do_enq & ~pass;
  assign deq_fire = do_deq & ~pass;

  // Writes are suppressed during flush and while reset holds, so memory is never disturbed.
  assign mem_W0_en   = enq_fire & ~flush & reset;
  assign mem_W0_addr = enq_ptr;
  assign mem_W0_data = enq_bits;
  assign mem_R0_addr = deq_ptr;
  assign mem_R0_en   = 1'b1;

  assign ptr_diff = enq_ptr - deq_ptr;
  assign count    = full ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);

  queue_wrap_ptr #(.ADDR_W(ADDR_W)) u_enq_ptr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (enq_fire),
    .value (enq_ptr)
  );

  queue_wrap_ptr #(.ADDR_W(ADDR_W)) u_deq_ptr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (deq_fire),
    .value (deq_ptr)
  );

  // Equal pointers are disambiguated by whether the last net change was an enqueue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      maybe_full <= 1'b0;
    end else if (flush) begin
      maybe_full <= 1'b0;
    end else if (enq_fire != deq_fire) begin
      maybe_full <= enq_fire;
    end
  end

endmodule

// File: tb/tb_queue_ctrl_2x115.sv
// Scoreboard bench for queue_ctrl_2x115 with a behavioural memory and queue model.
// Follows QUEUE_CTRL_FLOW_EN the same way the design does.
module tb_queue_ctrl_2x115;

  localparam int DATA_W = 115;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 1;
  localparam int CNT_W  = 2;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [DATA_W-1:0] mem_W0_data;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [DATA_W-1:0] mem_R0_data;

  logic [DATA_W-1:0] mem [DEPTH];

  typedef struct {
    logic              rdy;
    logic              vld;
    int                cnt;
    logic              wr;
    int                waddr;
    int                raddr;
    logic [DATA_W-1:0] wdata;
  } status_t;

  status_t           status_q[$];
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] ref_q[$];
  int                wr_ptr;
  int                rd_ptr;
  logic              mon_en;
  int                n_cmp;
  int                n_fail;
  status_t           st;

  queue_ctrl_2x115 dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_bits    (enq_bits),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_bits    (deq_bits),
    .count       (count),
    .mem_W0_addr (mem_W0_addr),
    .mem_W0_en   (mem_W0_en),
    .mem_W0_data (mem_W0_data),
    .mem_R0_addr (mem_R0_addr),
    .mem_R0_en   (mem_R0_en),
    .mem_R0_data (mem_R0_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_W0_en) mem[mem_W0_addr] <= mem_W0_data;
  end
  assign mem_R0_data = mem[mem_R0_addr];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  // Drives one cycle of inputs and records what the queue should do with them.
  task automatic applyStimulus(input logic ev, input logic [DATA_W-1:0] eb,
                               input logic dr, input logic fl);
    status_t s;
    int      sz;
    logic    enq_ok;
    logic    deq_ok;
    logic    bypass;
    @(posedge clock);
    #1;
    enq_valid = ev;
    enq_bits  = eb;
    deq_ready = dr;
    flush     = fl;
    sz        = ref_q.size();
    bypass    = 1'b0;
`ifdef QUEUE_CTRL_FLOW_EN
    bypass    = (sz == 0) && ev && dr;
    s.vld     = (sz > 0) || ev;
`else
    s.vld     = (sz > 0);
`endif
    s.rdy   = (sz < DEPTH);
    s.cnt   = sz;
    enq_ok  = ev && (sz < DEPTH) && !bypass;
    deq_ok  = dr && (sz > 0);
    s.wr    = enq_ok && !fl;
    s.waddr = wr_ptr;
    s.raddr = rd_ptr;
    s.wdata = eb;
    status_q.push_back(s);
    if (!fl) begin
      if (bypass) sb_q.push_back(eb);
      else if (deq_ok) sb_q.push_back(ref_q[0]);
    end
    if (fl) begin
      ref_q.delete();
      wr_ptr = 0;
      rd_ptr = 0;
    end else begin
      if (deq_ok) begin
        void'(ref_q.pop_front());
        rd_ptr = (rd_ptr + 1) % DEPTH;
      end
      if (enq_ok) begin
        ref_q.push_back(eb);
        wr_ptr = (wr_ptr + 1) % DEPTH;
      end
    end
  endtask

  // Monitor: compares each cycle's outputs and pops the scoreboard on every handshake.
  always @(negedge clock) begin
    if (mon_en && reset && status_q.size() > 0) begin
      st = status_q.pop_front();
      checkOutput("enq_ready", enq_ready, st.rdy);
      checkOutput("deq_valid", deq_valid, st.vld);
      checkOutput("count", count, st.cnt);
      checkOutput("mem_W0_en", mem_W0_en, st.wr);
      checkOutput("mem_R0_addr", mem_R0_addr, st.raddr);
      checkOutput("mem_R0_en", mem_R0_en, 1);
      if (st.wr && mem_W0_en) begin
        checkOutput("mem_W0_addr", mem_W0_addr, st.waddr);
        checkOutput("mem_W0_data", mem_W0_data, st.wdata);
      end
      if (deq_valid && deq_ready && !flush) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL deq_unexpected: got handshake with data %0h, expected none", deq_bits);
        end else begin
          checkOutput("deq_bits", deq_bits, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    clock     = 0;
    reset     = 0;
    flush     = 0;
    enq_valid = 0;
    enq_bits  = '0;
    deq_ready = 0;
    mon_en    = 0;
    n_cmp     = 0;
    n_fail    = 0;
    wr_ptr    = 0;
    rd_ptr    = 0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_enq_ready", enq_ready, 1);
    checkOutput("rst_deq_valid", deq_valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_mem_W0_en", mem_W0_en, 0);
    @(negedge clock);
    reset  = 1;
    mon_en = 1;

    repeat (5) applyStimulus(0, '0, 0, 0);

    applyStimulus(1, DATA_W'(1), 0, 0);
    applyStimulus(1, DATA_W'(2), 0, 0);
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);

    applyStimulus(1, DATA_W'('h10), 0, 0);
    for (int i = 1; i <= 16; i++) applyStimulus(1, DATA_W'('h10 + i), 1, 0);
    applyStimulus(0, '0, 0, 0);

    applyStimulus(1, DATA_W'('h30), 0, 0);
    applyStimulus(1, DATA_W'('h31), 1, 0);
    applyStimulus(1, DATA_W'('h32), 0, 0);
    applyStimulus(1, DATA_W'('h33), 0, 1);
    applyStimulus(0, '0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, rand_data(), ($urandom % 3) != 0, ($urandom % 20) == 0);
    end

    applyStimulus(0, '0, 0, 1);
    applyStimulus(1, DATA_W'('h55), 0, 0);
    applyStimulus(0, '0, 0, 0);
    @(negedge clock);
    #1;
    mon_en = 0;
    @(posedge clock);
    #2;
    reset = 0;
    #1;
    checkOutput("async_enq_ready", enq_ready, 1);
    checkOutput("async_deq_valid", deq_valid, 0);
    checkOutput("async_count", count, 0);
    checkOutput("async_mem_W0_en", mem_W0_en, 0);
    status_q.delete();
    sb_q.delete();
    ref_q.delete();
    wr_ptr = 0;
    rd_ptr = 0;
    @(negedge clock);
    #1;
    reset  = 1;
    mon_en = 1;

    applyStimulus(1, DATA_W'('hAB), 1, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 0, 0);
    @(negedge clock);
    #1;
    checkOutput("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
